// File: rtl/wifi_rx_mem_writer.sv
// Byte-stream to 32-bit RAM writer: packs received bytes little-endian and issues Avalon-MM writes.
// Optional per-packet checksum enabled by defining WIFI_RX_MEM_WRITER_CSUM_EN.
module wifi_rx_mem_writer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH_WORDS = 2500,
  parameter int unsigned BASE_WORD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_eop,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              pkt_done,
  output logic [15:0]       pkt_len,
  output logic              overflow,
  output logic [15:0]       pkt_csum
);

  // One spare bit so the address can sit at DEPTH_WORDS (the full marker) for any ADDR_W.
  localparam int unsigned AW = ADDR_W + 1;
  localparam logic [AW-1:0] BASE_A = AW'(BASE_WORD);
  localparam logic [AW-1:0] FULL_A = AW'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      be_q, be_d;
  logic            last_q, last_d;
  logic            ready_q, ready_d;
  logic            wr_q, wr_d;
  logic            done_q, done_d;
  logic [15:0]     len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            accept_s;
  logic            full_s;
  logic            first_s;
  logic [15:0]     len_base_s;
  logic            ovf_base_s;
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
  logic [15:0]     csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
    csum_d  = csum_q;
`endif
    accept_s   = s_valid & ready_q;
    full_s     = (addr_q == FULL_A);
    first_s    = (state_q == ST_IDLE);
    // The first byte of a packet restarts the per-packet status.
    len_base_s = first_s ? 16'h0000 : len_q;
    ovf_base_s = first_s ? 1'b0 : ovf_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept_s) begin
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
          csum_d = (first_s ? 16'h0000 : csum_q) + {8'h00, s_data};
`endif
          last_d = s_eop;
          if (full_s) begin
            len_d   = len_base_s;
            ovf_d   = 1'b1;
            state_d = s_eop ? ST_DONE : ST_ACCUM;
          end else begin
            data_d[{lane_q, 3'b000} +: 8] = s_data;
            be_d[lane_q] = 1'b1;
            lane_d  = lane_q + 2'd1;
            len_d   = (len_base_s == 16'hFFFF) ? len_base_s : len_base_s + 16'h0001;
            ovf_d   = ovf_base_s;
            state_d = ((lane_q == 2'd3) || s_eop) ? ST_WRITE : ST_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
          lane_d  = 2'd0;
          be_d    = 4'h0;
          data_d  = 32'h0000_0000;
          state_d = last_q ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        addr_d  = BASE_A;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they line up with state_q.
    ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    wr_d    = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lane_q  <= 2'd0;
      addr_q  <= BASE_A;
      data_q  <= 32'h0000_0000;
      be_q    <= 4'h0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= 16'h0000;
      ovf_q   <= 1'b0;
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
      csum_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign s_ready        = ready_q;
  assign avm_address    = addr_q[ADDR_W-1:0];
  assign avm_byteenable = be_q;
  assign avm_chipselect = wr_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = data_q;
  assign pkt_done       = done_q;
  assign pkt_len        = len_q;
  assign overflow       = ovf_q;
`ifdef WIFI_RX_MEM_WRITER_CSUM_EN
  assign pkt_csum       = csum_q;
`else
  assign pkt_csum       = 16'h0000;
`endif

endmodule

// File: doc/wifi_rx_mem_writer.md
Name: wifi_rx_mem_writer

Overview:
- Avalon-MM master that fills the system's 32-bit single-port on-chip RAM from a received byte stream (wifi/UART receive path).
- Packs bytes little-endian into 32-bit words and issues byte-enabled writes at incrementing word addresses starting at BASE_WORD.
- At end of packet it reports length and completion to the Nios-side control logic.
- Acts as the initiator end of the RAM's s1 write interface.

Parameters:
- ADDR_W, 12, word-address width; matches the RAM's 12-bit address.
- DEPTH_WORDS, 2500, number of valid RAM words; the last writable word is DEPTH_WORDS-1.
- BASE_WORD, 0, first word address of every packet.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s_data  input  8  received byte
- s_valid  input  1  byte valid
- s_eop  input  1  qualifies s_data as the last byte of the packet
- s_ready  output  1  block can accept a byte this cycle
- avm_address  output  ADDR_W  word address to the RAM
- avm_byteenable  output  4  lane enables
- avm_chipselect  output  1  RAM select
- avm_write  output  1  write strobe
- avm_writedata  output  32  packed word
- avm_waitrequest  input  1  slave stall; tie to 0 for the on-chip RAM
- pkt_done  output  1  one-cycle pulse after the last write of a packet
- pkt_len  output  16  accepted byte count of the last packet; held until the next packet's first byte
- overflow  output  1  sticky per packet; bytes dropped because memory was full
- pkt_csum  output  16  optional checksum (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; lane counter 0; address register set to BASE_WORD.
- A byte is accepted when s_valid & s_ready. s_ready = 1 in IDLE and ACCUM, 0 in WRITE and DONE.
- FSM states:
  - IDLE: the first accepted byte clears pkt_len, overflow and pkt_csum, then moves to ACCUM. The byte is processed exactly as in ACCUM.
  - ACCUM: an accepted byte goes to lane k = lane counter, i.e. data bits [8k+7:8k], and sets byteenable bit k. The lane counter increments. When lane 3 is filled or s_eop is seen, go to WRITE.
  - WRITE: drive avm_chipselect = avm_write = 1 with address, data and byteenable held stable until a cycle with avm_waitrequest = 0. In that cycle the write completes, the address increments, the lane counter and byteenable clear, and all data lanes clear. Next state is DONE if the packet ended, else ACCUM.
  - DONE: pkt_done = 1 for exactly one cycle; address returns to BASE_WORD; next state IDLE.
- Minimum throughput with waitrequest = 0: 4 bytes per 5 cycles.
- Partial final word: only the filled lanes are enabled. Example: 6 bytes gives byteenable 4'b1111 then 4'b0011. Unfilled lanes carry 0.
- pkt_len counts only the bytes actually written, saturating at 16'hFFFF.
- Full condition: while the address register equals DEPTH_WORDS, no write is issued.
  - Accepted bytes are dropped and overflow is set.
  - s_ready stays 1 so the source drains. ACCUM loops until s_eop, then goes to DONE without a write.
  - The address never exceeds DEPTH_WORDS and never wraps.
- s_eop with s_valid = 0 is ignored.
- Reset asserted mid-write: avm_write and avm_chipselect drop in the next cycle; the partial packet is abandoned and pkt_done is not pulsed.

Optional Feature:
- Macro: WIFI_RX_MEM_WRITER_CSUM_EN.
- Defined: pkt_csum is the 16-bit wrap-around sum of every accepted byte of the current packet, zero-extended, dropped bytes included. It is valid when pkt_done pulses and held until the next packet starts.
- Undefined: pkt_csum is constant 0 and no adder is synthesised.

Test Plan:
- Bytes 11,22,33,44,55 (eop on 55), waitrequest 0 → write addr 0 data 32'h44332211 be 4'hF; write addr 1 data 32'h00000055 be 4'h1; pkt_done one cycle later; pkt_len = 5; with the macro defined, pkt_csum = 16'h0FF.
- Same packet with waitrequest held high for 3 cycles on the first write → address, data and byteenable stable for 4 cycles; s_ready = 0 throughout; only 2 writes total.
- DEPTH_WORDS = 2, 12-byte packet → writes to addr 0 and 1 only; overflow = 1; pkt_len = 8; pkt_done pulses after the final byte.
- Two back-to-back 4-byte packets → both packets write to addr 0; overflow cleared at the start of the second; two pkt_done pulses.
- reset asserted in the WRITE cycle of the second word of a 7-byte packet → avm_write = 0 next cycle; no pkt_done; the next packet starts at addr 0 with pkt_len and overflow cleared.
